// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the decode-stage hazard controller: writeback select,
// opcode classes, forwarding codes, pending-flush states and operand-use decode.
package hazard_ctrl_pkg;

  localparam int WBSEL_W = 2;
  localparam logic [WBSEL_W-1:0] WBSEL_MEM = 2'd0;
  localparam logic [WBSEL_W-1:0] WBSEL_ALU = 2'd1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_E  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b11;

  // A taken branch seen during a memory freeze is remembered until the pipe moves.
  typedef enum logic {
    FL_IDLE = 1'b0,
    FL_PEND = 1'b1
  } flush_state_t;

  function automatic logic uses_rs1(input logic [6:0] opc);
    return !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return opc inside {OPC_OP, OPC_STORE, OPC_BRANCH};
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-stage hazard bus: instruction/control inputs from decode and execute,
// stall/flush/forward controls and event counters back out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import hazard_ctrl_pkg::*;

  logic [31:0]        inst_d_i;
  logic               RegWEn_d_i;
  logic [WBSEL_W-1:0] WBSel_d_i;
  logic               PCSel_e_i;
  logic               mem_busy_i;

  logic               pc_stop_o;
  logic               flush_fd_o;
  logic               pipeline_nop_o;
  logic               pipeline_flush_o;
  logic [1:0]         fwdA_sel_o;
  logic [1:0]         fwdB_sel_o;
  logic [CNT_W-1:0]   stall_cnt_o;
  logic [CNT_W-1:0]   flush_cnt_o;

  modport master (
    output inst_d_i, RegWEn_d_i, WBSel_d_i, PCSel_e_i, mem_busy_i,
    input  pc_stop_o, flush_fd_o, pipeline_nop_o, pipeline_flush_o,
    input  fwdA_sel_o, fwdB_sel_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  inst_d_i, RegWEn_d_i, WBSel_d_i, PCSel_e_i, mem_busy_i,
    output pc_stop_o, flush_fd_o, pipeline_nop_o, pipeline_flush_o,
    output fwdA_sel_o, fwdB_sel_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/hazard_slot.sv
// One shadow-scoreboard entry {valid, rd, wen, is_load}; hold beats bubble beats load.
// Registered, one-cycle update; a held slot ignores its inputs.
module hazard_slot #(
  parameter int RADDR_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               hold,
  input  logic               bubble,
  input  logic               valid_d,
  input  logic [RADDR_W-1:0] rd_d,
  input  logic               wen_d,
  input  logic               is_load_d,
  output logic               valid_q,
  output logic [RADDR_W-1:0] rd_q,
  output logic               wen_q,
  output logic               is_load_q
);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q   <= 1'b0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      is_load_q <= 1'b0;
    end else if (!hold) begin
      if (bubble) begin
        valid_q   <= 1'b0;
        rd_q      <= '0;
        wen_q     <= 1'b0;
        is_load_q <= 1'b0;
      end else begin
        valid_q   <= valid_d;
        rd_q      <= rd_d;
        wen_q     <= wen_d;
        is_load_q <= is_load_d;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: load-use stall, branch flush, operand forwarding.
// Controls are combinational in the cycle; the E/M/W shadow scoreboard advances at the edge.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int RADDR_W = 5
) (
  input logic          clk_i,
  input logic          rst_n_i,
  hazard_ctrl_if.slave hz
);

  logic [6:0]         opc;
  logic [RADDR_W-1:0] rs1, rs2, rd;
  logic               use1, use2;
  logic               unused_fields;

  assign opc  = hz.inst_d_i[6:0];
  assign rs1  = RADDR_W'(hz.inst_d_i[19:15]);
  assign rs2  = RADDR_W'(hz.inst_d_i[24:20]);
  assign rd   = RADDR_W'(hz.inst_d_i[11:7]);
  assign use1 = uses_rs1(opc);
  assign use2 = uses_rs2(opc);
  assign unused_fields = ^{hz.inst_d_i[31:25], hz.inst_d_i[14:12]};

  logic               e_vld, m_vld, w_vld;
  logic [RADDR_W-1:0] e_rd, m_rd, w_rd;
  logic               e_wen, m_wen, w_wen;
  logic               e_ld, m_ld, w_ld;
  logic               busy, flush_req, load_use, bubble_e;

  assign busy = hz.mem_busy_i;

  // Both a flush and a load-use stall inject a bubble into E; freeze wins over both.
  assign bubble_e = flush_req | load_use;

  hazard_slot #(.RADDR_W(RADDR_W)) u_slot_e (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .hold      (busy),
    .bubble    (bubble_e),
    .valid_d   (1'b1),
    .rd_d      (rd),
    .wen_d     (hz.RegWEn_d_i),
    .is_load_d (hz.WBSel_d_i == WBSEL_MEM),
    .valid_q   (e_vld),
    .rd_q      (e_rd),
    .wen_q     (e_wen),
    .is_load_q (e_ld)
  );

  hazard_slot #(.RADDR_W(RADDR_W)) u_slot_m (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .hold      (busy),
    .bubble    (1'b0),
    .valid_d   (e_vld),
    .rd_d      (e_rd),
    .wen_d     (e_wen),
    .is_load_d (e_ld),
    .valid_q   (m_vld),
    .rd_q      (m_rd),
    .wen_q     (m_wen),
    .is_load_q (m_ld)
  );

  hazard_slot #(.RADDR_W(RADDR_W)) u_slot_w (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .hold      (busy),
    .bubble    (1'b0),
    .valid_d   (m_vld),
    .rd_d      (m_rd),
    .wen_d     (m_wen),
    .is_load_d (m_ld),
    .valid_q   (w_vld),
    .rd_q      (w_rd),
    .wen_q     (w_wen),
    .is_load_q (w_ld)
  );

  function automatic logic hit(input logic v, input logic w,
                               input logic [RADDR_W-1:0] r,
                               input logic [RADDR_W-1:0] rs);
    return v & w & (r != '0) & (r == rs);
  endfunction

  logic hit_e1, hit_m1, hit_w1, hit_e2, hit_m2, hit_w2;
  logic unused_wld;

  assign hit_e1 = hit(e_vld, e_wen, e_rd, rs1);
  assign hit_m1 = hit(m_vld, m_wen, m_rd, rs1);
  assign hit_w1 = hit(w_vld, w_wen, w_rd, rs1);
  assign hit_e2 = hit(e_vld, e_wen, e_rd, rs2);
  assign hit_m2 = hit(m_vld, m_wen, m_rd, rs2);
  assign hit_w2 = hit(w_vld, w_wen, w_rd, rs2);
  assign unused_wld = w_ld;

  assign load_use = e_ld & ((use1 & hit_e1) | (use2 & hit_e2));

  // A load in E has no data yet, so its hit falls through to older producers.
  always_comb begin
    hz.fwdA_sel_o = FWD_RF;
    if (hit_e1 && !e_ld)  hz.fwdA_sel_o = FWD_E;
    else if (hit_m1)      hz.fwdA_sel_o = FWD_M;
    else if (hit_w1)      hz.fwdA_sel_o = FWD_W;

    hz.fwdB_sel_o = FWD_RF;
    if (hit_e2 && !e_ld)  hz.fwdB_sel_o = FWD_E;
    else if (hit_m2)      hz.fwdB_sel_o = FWD_M;
    else if (hit_w2)      hz.fwdB_sel_o = FWD_W;
  end

  flush_state_t fl_st, fl_nxt;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) fl_st <= FL_IDLE;
    else          fl_st <= fl_nxt;
  end

  assign flush_req = hz.PCSel_e_i | (fl_st == FL_PEND);

  always_comb begin
    fl_nxt              = fl_st;
    hz.pc_stop_o        = 1'b0;
    hz.flush_fd_o       = 1'b0;
    hz.pipeline_nop_o   = 1'b0;
    hz.pipeline_flush_o = 1'b0;

    case (fl_st)
      FL_IDLE: if (busy && hz.PCSel_e_i) fl_nxt = FL_PEND;
      FL_PEND: if (!busy)                fl_nxt = FL_IDLE;
      default:                           fl_nxt = FL_IDLE;
    endcase

    if (busy) begin
      hz.pc_stop_o = 1'b1;
    end else if (flush_req) begin
      hz.pipeline_flush_o = 1'b1;
      hz.flush_fd_o       = 1'b1;
    end else if (load_use) begin
      hz.pipeline_nop_o = 1'b1;
      hz.pc_stop_o      = 1'b1;
    end
  end

  logic             stall_evt, flush_evt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  assign stall_evt = !busy && !flush_req && load_use;
  assign flush_evt = !busy && flush_req;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.stall_cnt_o = stall_cnt;
  assign hz.flush_cnt_o = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios then random traffic, all
// compared against an instruction-history model of the hazard rules.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  logic clk_i = 1'b0;
  logic rst_n_i;
  always #5 clk_i = ~clk_i;

  logic [31:0] d_inst;
  logic        d_wen;
  logic [1:0]  d_wbsel;
  logic        d_pcsel;
  logic        d_busy;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();
  assign hz.inst_d_i   = d_inst;
  assign hz.RegWEn_d_i = d_wen;
  assign hz.WBSel_d_i  = d_wbsel;
  assign hz.PCSel_e_i  = d_pcsel;
  assign hz.mem_busy_i = d_busy;

  hazard_ctrl #(.CNT_W(CNT_W), .RADDR_W(5)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .hz      (hz)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model: the last three instructions that left decode, newest first (bubbles included).
  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       wen;
    logic       ld;
  } ent_t;

  ent_t hist[$];
  bit   m_pend;
  int   m_stall, m_flush;
  bit   m_lu, m_fr;

  function automatic int src_of(input logic [4:0] rs);
    for (int d = 0; d < hist.size(); d++)
      if (hist[d].vld && hist[d].wen && hist[d].rd != 5'd0 && hist[d].rd == rs &&
          !(d == 0 && hist[d].ld))
        return d + 1;
    return 0;
  endfunction

  task automatic model_check();
    logic [6:0] opc = d_inst[6:0];
    logic [4:0] rs1 = d_inst[19:15];
    logic [4:0] rs2 = d_inst[24:20];
    bit u1 = !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    bit u2 = opc inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    bit e_pc = 0, e_fd = 0, e_nop = 0, e_fl = 0;
    m_lu = 0;
    if (hist.size() > 0 && hist[0].vld && hist[0].wen && hist[0].ld && hist[0].rd != 5'd0)
      m_lu = (u1 && hist[0].rd == rs1) || (u2 && hist[0].rd == rs2);
    m_fr = d_pcsel || m_pend;
    if (d_busy) e_pc = 1;
    else if (m_fr) begin e_fl = 1; e_fd = 1; end
    else if (m_lu) begin e_nop = 1; e_pc = 1; end
    chk("pc_stop",   32'(hz.pc_stop_o),        32'(e_pc));
    chk("flush_fd",  32'(hz.flush_fd_o),       32'(e_fd));
    chk("nop",       32'(hz.pipeline_nop_o),   32'(e_nop));
    chk("flush",     32'(hz.pipeline_flush_o), 32'(e_fl));
    chk("fwdA",      32'(hz.fwdA_sel_o),       32'(src_of(rs1)));
    chk("fwdB",      32'(hz.fwdB_sel_o),       32'(src_of(rs2)));
    chk("stall_cnt", 32'(hz.stall_cnt_o),      32'(m_stall > SAT ? SAT : m_stall));
    chk("flush_cnt", 32'(hz.flush_cnt_o),      32'(m_flush > SAT ? SAT : m_flush));
  endtask

  task automatic model_update();
    ent_t n;
    if (!rst_n_i) begin
      hist.delete();
      m_pend  = 0;
      m_stall = 0;
      m_flush = 0;
    end else if (d_busy) begin
      m_pend = m_pend | d_pcsel;
    end else begin
      if (m_fr) begin m_flush++; n = '0; end
      else if (m_lu) begin m_stall++; n = '0; end
      else n = '{vld: 1'b1, rd: d_inst[11:7], wen: d_wen, ld: (d_wbsel == WBSEL_MEM)};
      hist.push_front(n);
      if (hist.size() > 3) void'(hist.pop_back());
      m_pend = 0;
    end
  endtask

  // Enter just after a rising edge; leave just after the next one.
  task automatic tick(input bit do_chk);
    @(negedge clk_i);
    if (do_chk) model_check();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic drv(input logic [31:0] ins, input logic wen, input logic [1:0] wb,
                     input logic pc, input logic bz);
    d_inst = ins; d_wen = wen; d_wbsel = wb; d_pcsel = pc; d_busy = bz;
  endtask

  function automatic logic [31:0] r_type(input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), OPC_OP};
  endfunction

  function automatic logic [31:0] i_type(input logic [6:0] opc, input int rd, input int rs1,
                                         input int imm);
    return {12'(imm), 5'(rs1), (opc == OPC_LOAD) ? 3'b010 : 3'b000, 5'(rd), opc};
  endfunction

  logic [31:0] nop_i, lw5, add6, ins;
  logic [6:0]  opcs [8] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_STORE, OPC_BRANCH,
                            OPC_LOAD, OPC_OPIMM};

  initial begin
    nop_i = i_type(OPC_OPIMM, 0, 0, 0);
    lw5   = i_type(OPC_LOAD, 5, 1, 0);
    add6  = r_type(6, 5, 2);
    rst_n_i = 1'b0;
    drv(nop_i, 1'b1, WBSEL_ALU, 1'b0, 1'b0);
    tick(0);
    tick(1);
    rst_n_i = 1'b1;
    #2;
    chk("rst_pc_stop", 32'(hz.pc_stop_o), 32'd0);
    chk("rst_nop",     32'(hz.pipeline_nop_o), 32'd0);
    chk("rst_cnt",     32'(hz.stall_cnt_o), 32'd0);
    tick(1);

    // Load-use: lw x5 then add x6,x5,x2
    drv(lw5, 1'b1, WBSEL_MEM, 1'b0, 1'b0); tick(1);
    drv(add6, 1'b1, WBSEL_ALU, 1'b0, 1'b0); #2;
    chk("lu_nop", 32'(hz.pipeline_nop_o), 32'd1);
    chk("lu_pc_stop", 32'(hz.pc_stop_o), 32'd1);
    tick(1); #2;
    chk("lu_fwdA_after", 32'(hz.fwdA_sel_o), 32'(FWD_M));
    chk("lu_stall_cnt", 32'(hz.stall_cnt_o), 32'd1);
    tick(1);

    // ALU chain
    drv(i_type(OPC_OPIMM, 3, 0, 1), 1'b1, WBSEL_ALU, 1'b0, 1'b0); tick(1);
    drv(r_type(4, 3, 3), 1'b1, WBSEL_ALU, 1'b0, 1'b0); #2;
    chk("chain_fwdA1", 32'(hz.fwdA_sel_o), 32'(FWD_E));
    chk("chain_fwdB1", 32'(hz.fwdB_sel_o), 32'(FWD_E));
    tick(1);
    drv(r_type(7, 3, 4), 1'b1, WBSEL_ALU, 1'b0, 1'b0); #2;
    chk("chain_fwdA2", 32'(hz.fwdA_sel_o), 32'(FWD_M));
    chk("chain_fwdB2", 32'(hz.fwdB_sel_o), 32'(FWD_E));
    chk("chain_nop", 32'(hz.pipeline_nop_o), 32'd0);
    tick(1);

    // x0 writes are never forwarded
    drv(i_type(OPC_OPIMM, 0, 0, 5), 1'b1, WBSEL_ALU, 1'b0, 1'b0); tick(1);
    drv(r_type(1, 0, 0), 1'b1, WBSEL_ALU, 1'b0, 1'b0); #2;
    chk("x0_fwdA", 32'(hz.fwdA_sel_o), 32'd0);
    chk("x0_fwdB", 32'(hz.fwdB_sel_o), 32'd0);
    tick(1);

    // Branch coinciding with load-use: flush wins
    drv(lw5, 1'b1, WBSEL_MEM, 1'b0, 1'b0); tick(1);
    drv(add6, 1'b1, WBSEL_ALU, 1'b1, 1'b0); #2;
    chk("br_flush", 32'(hz.pipeline_flush_o), 32'd1);
    chk("br_flush_fd", 32'(hz.flush_fd_o), 32'd1);
    chk("br_nop", 32'(hz.pipeline_nop_o), 32'd0);
    tick(1);
    drv(nop_i, 1'b1, WBSEL_ALU, 1'b0, 1'b0); #2;
    chk("br_flush_cnt", 32'(hz.flush_cnt_o), 32'd1);
    chk("br_stall_cnt", 32'(hz.stall_cnt_o), 32'd1);
    tick(1);

    // Branch during a 3-cycle freeze
    drv(i_type(OPC_OPIMM, 3, 0, 1), 1'b1, WBSEL_ALU, 1'b0, 1'b0); tick(1);
    for (int k = 0; k < 3; k++) begin
      drv(r_type(4, 3, 3), 1'b1, WBSEL_ALU, 1'b1, 1'b1); #2;
      chk("frz_flush", 32'(hz.pipeline_flush_o), 32'd0);
      chk("frz_fwdA", 32'(hz.fwdA_sel_o), 32'(FWD_E));
      tick(1);
    end
    drv(r_type(4, 3, 3), 1'b1, WBSEL_ALU, 1'b0, 1'b0); #2;
    chk("frz_release_flush", 32'(hz.pipeline_flush_o), 32'd1);
    chk("frz_release_fwdA", 32'(hz.fwdA_sel_o), 32'(FWD_E));
    tick(1);
    drv(nop_i, 1'b1, WBSEL_ALU, 1'b0, 1'b0); #2;
    chk("frz_flush_cnt", 32'(hz.flush_cnt_o), 32'd2);
    tick(1);

    // Reset during a load-use stall
    drv(lw5, 1'b1, WBSEL_MEM, 1'b0, 1'b0); tick(1);
    drv(add6, 1'b1, WBSEL_ALU, 1'b0, 1'b0);
    rst_n_i = 1'b0; tick(1);
    rst_n_i = 1'b1; #2;
    chk("rst6_nop", 32'(hz.pipeline_nop_o), 32'd0);
    chk("rst6_pc_stop", 32'(hz.pc_stop_o), 32'd0);
    chk("rst6_fwdA", 32'(hz.fwdA_sel_o), 32'd0);
    chk("rst6_stall_cnt", 32'(hz.stall_cnt_o), 32'd0);
    chk("rst6_flush_cnt", 32'(hz.flush_cnt_o), 32'd0);
    tick(1);

    // Random traffic on a small register set so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      ins = $urandom();
      ins[6:0]   = opcs[$urandom_range(0, 7)];
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      drv(ins, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 2)),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
      rst_n_i = ($urandom_range(0, 199) != 0);
      tick(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
